mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single physical memory port between instruction fetch (IFU, read-only) and the
//  memory stage (LSU, load/store). Accepts one request at a time, drives the downstream port,
//  waits for its response and returns it to the owning requester. One outstanding transaction.
//  Sits between the IF/MEM pipeline stages and the memory/DPI bridge.
// PARAMETERS
//  XLEN        64   data/address width
//  STARVE_MAX  4    consecutive LSU grants allowed while IFU is waiting; 0 = pure LSU priority
//  TIMEOUT     256  cycles in WAIT before the transaction is aborted with error
// PORTS
//  clk             in   1     clock, all state on posedge
//  rst             in   1     asynchronous reset, active-high
//  ifu_req_valid_i in   1     IFU read request
//  ifu_req_ready_o out  1     IFU request accepted when valid&ready
//  ifu_addr_i      in   XLEN  fetch address
//  ifu_resp_valid_o out 1     one-cycle pulse, fetch data valid
//  ifu_resp_data_o out  XLEN  fetched data (low 32 bits = instruction)
//  ifu_resp_err_o  out  1     valid with ifu_resp_valid_o; timeout abort
//  lsu_req_valid_i in   1     LSU request
//  lsu_req_ready_o out  1     LSU request accepted when valid&ready
//  lsu_we_i        in   1     1 = store, 0 = load
//  lsu_addr_i      in   XLEN  byte address
//  lsu_wdata_i     in   XLEN  store data
//  lsu_mask_i      in   8     byte mask (rmask for load, wmask for store)
//  lsu_resp_valid_o out 1     one-cycle pulse; load data valid / store complete
//  lsu_resp_data_o out  XLEN  load data (0 for stores)
//  lsu_resp_err_o  out  1     valid with lsu_resp_valid_o; timeout abort
//  mem_req_valid_o out  1     downstream request
//  mem_req_ready_i in   1     downstream accepts when valid&ready
//  mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o(8), mem_rmask_o(8)  out  registered request fields
//  mem_resp_valid_i in  1     downstream response (loads and stores)
//  mem_resp_data_i in   XLEN  downstream read data
//  busy_o          out  1     state != IDLE
// BEHAVIOUR
//  Reset: state IDLE, all *_valid_o/err/busy 0, data/addr/mask outputs 0, streak and timer 0.
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE : req_ready_o = 1 only for the granted requester (ready is combinational from valids).
//          Grant: LSU if lsu_req_valid_i, unless ifu_req_valid_i && streak == STARVE_MAX (STARVE_MAX != 0).
//          On handshake capture owner, we, addr, wdata, masks -> ISSUE. IFU: we=0, rmask=8'h0F.
//   ISSUE: mem_req_valid_o = 1 with captured fields held stable; on mem_req_ready_i -> WAIT.
//   WAIT : on mem_resp_valid_i capture data (0 for stores) -> RESP. Timer counts from 0;
//          timer == TIMEOUT-1 without response -> RESP with err=1, data=0.
//   RESP : owner resp_valid_o = 1 for exactly one cycle, then IDLE. No request accepted in RESP.
//  Masks: wmask = store ? mask : 0; rmask = load ? mask : 0.
//  Streak: +1 on LSU grant while ifu_req_valid_i = 1 (saturate at STARVE_MAX); cleared on IFU grant
//   or LSU grant with IFU idle.
//  Latency: handshake cycle N, mem_req_valid_o at N+1; ready at N+1, response at N+2 ->
//   resp_valid_o at N+3. Minimum 3 cycles request-to-response.
//  Simultaneous IFU+LSU valid: exactly one ready asserted. mem_resp_valid_i outside WAIT is ignored.
//  Response arriving same cycle as timeout terminal count: response wins, err=0.
//  Reset mid-operation: immediate return to IDLE, mem_req_valid_o and resp pulses drop asynchronously;
//   in-flight downstream response discarded.
// STRUCTURE
//  sysconfig.v: `XLEN, state encodings (`ARB_IDLE..`ARB_RESP), owner encoding, IFU rmask constant.
//  Sub-module mem_arb_pick: grant decision + starvation streak counter. Rest in one module.
// TESTING
//  1 IFU read 0x8000_0000, ready immediate, resp 1 cycle later data 0x00000413 -> ifu_resp_valid at N+3, data match.
//  2 LSU SW addr 0x8000_0100 wdata 0xDEADBEEF mask 0x0F -> mem_wmask 0x0F, mem_rmask 0, lsu_resp_valid, data 0.
//  3 IFU+LSU valid continuously, STARVE_MAX=4 -> grant order L,L,L,L,I repeating; never 6 LSU in a row.
//  4 mem_req_ready_i low 10 cycles -> fields stable, mem_req_valid_o held, no resp until accepted.
//  5 no mem_resp_valid_i for TIMEOUT cycles -> resp_valid with err=1, data 0, back to IDLE, next request served.
//  6 assert rst in WAIT -> outputs 0 same cycle; late mem_resp_valid_i after reset produces no resp pulse.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU memory port arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_e;

  // Instruction fetch reads the low word only.
  localparam logic [7:0] IFU_RMASK = 8'h0F;

  function automatic logic [7:0] sel_mask(input logic en, input logic [7:0] m);
    return en ? m : 8'h00;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant decision between IFU and LSU with a bounded LSU streak so fetch cannot starve.
module mem_arb_pick #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle_i,
  input  logic ifu_valid_i,
  input  logic lsu_valid_i,
  output logic grant_ifu_o,
  output logic grant_lsu_o
);
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [SW-1:0] streak_q, streak_d;
  logic          starve;

  // STARVE_MAX == 0 disables the override: LSU always wins.
  assign starve      = (STARVE_MAX != 0) && ifu_valid_i && (streak_q == SMAX);
  assign grant_lsu_o = idle_i && lsu_valid_i && !starve;
  assign grant_ifu_o = idle_i && ifu_valid_i && !grant_lsu_o;

  always_comb begin
    streak_d = streak_q;
    if (grant_lsu_o) begin
      if (!ifu_valid_i)            streak_d = '0;
      else if (streak_q != SMAX)   streak_d = streak_q + SW'(1);
    end else if (grant_ifu_o) begin
      streak_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) streak_q <= '0;
    else     streak_q <= streak_d;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch and load/store.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ifu_req_valid_i,
  output logic            ifu_req_ready_o,
  input  logic [XLEN-1:0] ifu_addr_i,
  output logic            ifu_resp_valid_o,
  output logic [XLEN-1:0] ifu_resp_data_o,
  output logic            ifu_resp_err_o,
  input  logic            lsu_req_valid_i,
  output logic            lsu_req_ready_o,
  input  logic            lsu_we_i,
  input  logic [XLEN-1:0] lsu_addr_i,
  input  logic [XLEN-1:0] lsu_wdata_i,
  input  logic [7:0]      lsu_mask_i,
  output logic            lsu_resp_valid_o,
  output logic [XLEN-1:0] lsu_resp_data_o,
  output logic            lsu_resp_err_o,
  output logic            mem_req_valid_o,
  input  logic            mem_req_ready_i,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [7:0]      mem_wmask_o,
  output logic [7:0]      mem_rmask_o,
  input  logic            mem_resp_valid_i,
  input  logic [XLEN-1:0] mem_resp_data_i,
  output logic            busy_o
);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  arb_state_e      state_q, state_d;
  arb_owner_e      owner_q, owner_d;
  logic            we_q, we_d, err_q, err_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [7:0]      wmask_q, wmask_d, rmask_q, rmask_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            grant_ifu, grant_lsu;

  mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .clk         (clk),
    .rst         (rst),
    .idle_i      (state_q == ARB_IDLE),
    .ifu_valid_i (ifu_req_valid_i),
    .lsu_valid_i (lsu_req_valid_i),
    .grant_ifu_o (grant_ifu),
    .grant_lsu_o (grant_lsu)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rmask_d = rmask_q;
    timer_d = timer_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant_lsu) begin
          owner_d = OWN_LSU;
          we_d    = lsu_we_i;
          addr_d  = lsu_addr_i;
          wdata_d = lsu_wdata_i;
          wmask_d = sel_mask(lsu_we_i, lsu_mask_i);
          rmask_d = sel_mask(!lsu_we_i, lsu_mask_i);
          state_d = ARB_ISSUE;
        end else if (grant_ifu) begin
          owner_d = OWN_IFU;
          we_d    = 1'b0;
          addr_d  = ifu_addr_i;
          wdata_d = '0;
          wmask_d = 8'h00;
          rmask_d = IFU_RMASK;
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (mem_req_ready_i) begin
          timer_d = '0;
          state_d = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        // A response on the terminal-count cycle still completes cleanly.
        if (mem_resp_valid_i) begin
          rdata_d = we_q ? '0 : mem_resp_data_i;
          err_d   = 1'b0;
          state_d = ARB_RESP;
        end else if (timer_q == TLAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ARB_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_IFU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rmask_q <= '0;
      timer_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rmask_q <= rmask_d;
      timer_q <= timer_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign ifu_req_ready_o  = grant_ifu;
  assign lsu_req_ready_o  = grant_lsu;
  assign mem_req_valid_o  = (state_q == ARB_ISSUE);
  assign mem_we_o         = we_q;
  assign mem_addr_o       = addr_q;
  assign mem_wdata_o      = wdata_q;
  assign mem_wmask_o      = wmask_q;
  assign mem_rmask_o      = rmask_q;
  assign busy_o           = (state_q != ARB_IDLE);

  assign ifu_resp_valid_o = (state_q == ARB_RESP) && (owner_q == OWN_IFU);
  assign lsu_resp_valid_o = (state_q == ARB_RESP) && (owner_q == OWN_LSU);
  assign ifu_resp_data_o  = ifu_resp_valid_o ? rdata_q : '0;
  assign lsu_resp_data_o  = lsu_resp_valid_o ? rdata_q : '0;
  assign ifu_resp_err_o   = ifu_resp_valid_o && err_q;
  assign lsu_resp_err_o   = lsu_resp_valid_o && err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: vector table, scoreboard of expected responses, corner sequences.
module tb_mem_bus_arbiter;
  localparam int XLEN = 64;
  localparam int SMAX = 4;
  localparam int TMO  = 256;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ifu_req_valid_i = 1'b0, ifu_req_ready_o;
  logic [XLEN-1:0] ifu_addr_i = '0;
  logic            ifu_resp_valid_o, ifu_resp_err_o;
  logic [XLEN-1:0] ifu_resp_data_o;
  logic            lsu_req_valid_i = 1'b0, lsu_req_ready_o, lsu_we_i = 1'b0;
  logic [XLEN-1:0] lsu_addr_i = '0, lsu_wdata_i = '0;
  logic [7:0]      lsu_mask_i = '0;
  logic            lsu_resp_valid_o, lsu_resp_err_o;
  logic [XLEN-1:0] lsu_resp_data_o;
  logic            mem_req_valid_o, mem_req_ready_i = 1'b0, mem_we_o;
  logic [XLEN-1:0] mem_addr_o, mem_wdata_o;
  logic [7:0]      mem_wmask_o, mem_rmask_o;
  logic            mem_resp_valid_i = 1'b0;
  logic [XLEN-1:0] mem_resp_data_i = '0;
  logic            busy_o;

  mem_bus_arbiter #(.XLEN(XLEN), .STARVE_MAX(SMAX), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid_i(ifu_req_valid_i), .ifu_req_ready_o(ifu_req_ready_o), .ifu_addr_i(ifu_addr_i),
    .ifu_resp_valid_o(ifu_resp_valid_o), .ifu_resp_data_o(ifu_resp_data_o), .ifu_resp_err_o(ifu_resp_err_o),
    .lsu_req_valid_i(lsu_req_valid_i), .lsu_req_ready_o(lsu_req_ready_o), .lsu_we_i(lsu_we_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_mask_i(lsu_mask_i),
    .lsu_resp_valid_o(lsu_resp_valid_o), .lsu_resp_data_o(lsu_resp_data_o), .lsu_resp_err_o(lsu_resp_err_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o), .mem_rmask_o(mem_rmask_o),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_data_i(mem_resp_data_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            lsu;
    logic            err;
    logic [XLEN-1:0] data;
  } exp_t;

  typedef struct {
    logic            lsu;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [7:0]      mask;
    logic [XLEN-1:0] mrd;
    logic [7:0]      ewm;
    logic [7:0]      erm;
    logic [XLEN-1:0] edata;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vt[6];
  int   total = 0, bad = 0;
  int   cyc = 0, resp_cnt = 0, last_resp_cyc = -1;

  task automatic chk64(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: every pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (ifu_resp_valid_o || lsu_resp_valid_o) begin
      chk1("resp_onehot", ifu_resp_valid_o && lsu_resp_valid_o, 1'b0);
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_resp: got ifu=%0b lsu=%0b want none (cyc %0d)",
                 ifu_resp_valid_o, lsu_resp_valid_o, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk1("resp_owner", lsu_resp_valid_o, mon_e.lsu);
        chk64("resp_data", lsu_resp_valid_o ? lsu_resp_data_o : ifu_resp_data_o, mon_e.data);
        chk1("resp_err", lsu_resp_valid_o ? lsu_resp_err_o : ifu_resp_err_o, mon_e.err);
      end
      resp_cnt++;
      last_resp_cyc = cyc;
    end
  end

  // Raise one request and wait (bounded) for its handshake edge.
  task automatic req_only(input vec_t v, output bit ok);
    if (v.lsu) begin
      lsu_req_valid_i = 1'b1; lsu_we_i = v.we; lsu_addr_i = v.addr;
      lsu_wdata_i = v.wdata; lsu_mask_i = v.mask;
    end else begin
      ifu_req_valid_i = 1'b1; ifu_addr_i = v.addr;
    end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (v.lsu ? lsu_req_ready_o : ifu_req_ready_o) ok = 1'b1;
      tick();
    end
    ifu_req_valid_i = 1'b0;
    lsu_req_valid_i = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL req_accept: got no ready in 20 cycles want handshake (cyc %0d)", cyc);
    end
  endtask

  task automatic do_txn(input vec_t v, input int rd, input int dd, input bit tmo);
    int h, rc0; bit ok; exp_t e;
    rc0 = resp_cnt;
    req_only(v, ok);
    if (!ok) return;
    h = cyc;
    e.lsu = v.lsu; e.err = tmo; e.data = tmo ? '0 : v.edata;
    sb.push_back(e);
    for (int i = 0; i <= rd; i++) begin
      chk1("issue_valid", mem_req_valid_o, 1'b1);
      chk1("issue_we", mem_we_o, v.lsu & v.we);
      chk64("issue_addr", mem_addr_o, v.addr);
      chk64("issue_wdata", mem_wdata_o, v.lsu ? v.wdata : '0);
      chk64("issue_wmask", 64'(mem_wmask_o), 64'(v.ewm));
      chk64("issue_rmask", 64'(mem_rmask_o), 64'(v.erm));
      if (i < rd) tick();
    end
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    chk1("wait_req_low", mem_req_valid_o, 1'b0);
    if (!tmo) begin
      repeat (dd) tick();
      mem_resp_valid_i = 1'b1; mem_resp_data_i = v.mrd;
      tick();
      mem_resp_valid_i = 1'b0; mem_resp_data_i = '0;
      tick();
      chk64("resp_cycle", 64'(last_resp_cyc), 64'(h + 2 + rd + dd));
    end else begin
      for (int i = 0; i < TMO + 20 && resp_cnt == rc0; i++) tick();
      chk64("tmo_cycle", 64'(last_resp_cyc), 64'(h + 1 + rd + TMO));
    end
    chk64("resp_count", 64'(resp_cnt), 64'(rc0 + 1));
    chk1("idle_after", busy_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ms, rc0;
    bit ok, exp_lsu;
    vec_t va;

    vt[0] = '{1'b0, 1'b0, 64'h8000_0000, 64'h0, 8'h00, 64'h0000_0413, 8'h00, 8'h0F, 64'h0000_0413};
    vt[1] = '{1'b1, 1'b1, 64'h8000_0100, 64'hDEAD_BEEF, 8'h0F, 64'h5555_AAAA, 8'h0F, 8'h00, 64'h0};
    vt[2] = '{1'b1, 1'b0, 64'h8000_0200, 64'h0, 8'hFF, 64'h0123_4567_89AB_CDEF, 8'h00, 8'hFF, 64'h0123_4567_89AB_CDEF};
    vt[3] = '{1'b1, 1'b1, 64'h8000_0303, 64'hAA, 8'h08, 64'h77, 8'h08, 8'h00, 64'h0};
    vt[4] = '{1'b0, 1'b0, 64'h8000_0004, 64'h0, 8'h00, 64'hFFFF_FFFF_0000_0013, 8'h00, 8'h0F, 64'hFFFF_FFFF_0000_0013};
    vt[5] = '{1'b1, 1'b0, 64'h8000_040C, 64'h0, 8'h30, 64'h0000_BEEF_0000_0000, 8'h00, 8'h30, 64'h0000_BEEF_0000_0000};

    repeat (3) tick();
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_memvalid", mem_req_valid_o, 1'b0);
    chk1("rst_ifu_resp", ifu_resp_valid_o, 1'b0);
    chk1("rst_lsu_resp", lsu_resp_valid_o, 1'b0);
    chk64("rst_addr", mem_addr_o, '0);
    chk64("rst_masks", 64'({mem_wmask_o, mem_rmask_o}), 64'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) do_txn(vt[i], 0, i % 2, 1'b0);

    // Downstream stalls for 10 cycles.
    do_txn(vt[2], 10, 0, 1'b0);

    // No downstream response: abort with error, then a normal fetch.
    do_txn(vt[2], 0, 0, 1'b1);
    do_txn(vt[0], 0, 0, 1'b0);

    // Continuous contention: LSU streak capped at SMAX, then one IFU grant.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    ms = 0;
    ifu_req_valid_i = 1'b1; ifu_addr_i = 64'h8000_1000;
    lsu_req_valid_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 64'h8000_2000; lsu_mask_i = 8'hFF;
    for (int k = 0; k < 12; k++) begin
      rc0 = resp_cnt;
      @(negedge clk);
      chk1("arb_onehot", ifu_req_ready_o ^ lsu_req_ready_o, 1'b1);
      exp_lsu = (ms != SMAX);
      chk1($sformatf("arb_grant%0d", k), lsu_req_ready_o, exp_lsu);
      ms = exp_lsu ? ((ms < SMAX) ? ms + 1 : ms) : 0;
      sb.push_back('{exp_lsu, 1'b0, 64'h1000 + 64'(k)});
      tick();
      chk64("arb_rmask", 64'(mem_rmask_o), exp_lsu ? 64'hFF : 64'h0F);
      mem_req_ready_i = 1'b1; tick(); mem_req_ready_i = 1'b0;
      mem_resp_valid_i = 1'b1; mem_resp_data_i = 64'h1000 + 64'(k);
      tick();
      mem_resp_valid_i = 1'b0;
      tick();
      chk64("arb_resp_count", 64'(resp_cnt), 64'(rc0 + 1));
    end
    ifu_req_valid_i = 1'b0; lsu_req_valid_i = 1'b0;
    tick();

    // Reset while the request is on the bus.
    va = vt[2];
    req_only(va, ok);
    chk1("issue_before_rst", mem_req_valid_o, 1'b1);
    rst = 1'b1; #1;
    chk1("rst_issue_memvalid", mem_req_valid_o, 1'b0);
    chk1("rst_issue_busy", busy_o, 1'b0);
    tick(); rst = 1'b0; tick();

    // Reset while waiting; late response must be dropped.
    rc0 = resp_cnt;
    req_only(va, ok);
    mem_req_ready_i = 1'b1; tick(); mem_req_ready_i = 1'b0;
    repeat (2) tick();
    chk1("wait_busy", busy_o, 1'b1);
    rst = 1'b1; #1;
    chk1("rst_wait_busy", busy_o, 1'b0);
    chk64("rst_wait_addr", mem_addr_o, '0);
    tick(); rst = 1'b0;
    mem_resp_valid_i = 1'b1; mem_resp_data_i = 64'hBAD;
    tick();
    mem_resp_valid_i = 1'b0;
    repeat (3) tick();
    chk64("late_resp_dropped", 64'(resp_cnt), 64'(rc0));
    chk1("late_busy", busy_o, 1'b0);
    do_txn(vt[1], 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
